prescaled_counter_bank: RTL and testbench
=========================================

Name: prescaled_counter_bank

Overview:
Parametrised bank of NCH event counters, WIDTH bits each, for the lab's counting/timing exercises.
- Each enabled cycle delivers one event to the channel addressed by Sel.
- Each channel has a runtime-programmable prescaler: the main count advances once per (Div+1) events.
- Per-channel clear, a config-write port, and a wrap/overflow indication.

Parameters:
- WIDTH, 64, bits per channel counter (>=2).
- NCH, 2, number of channels (>=2).
- DIV_W, 2, prescaler width; divide ratio is 1..2^DIV_W.
- SEL_W, $clog2(NCH), channel-select width (derived; do not override).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  reset; synchronous, active-high.
- En  in  1  event strobe; one event per cycle while high.
- Sel  in  SEL_W  channel receiving the event.
- Clr  in  1  clear strobe.
- ClrSel  in  SEL_W  channel to clear.
- CfgWe  in  1  prescaler config write strobe.
- CfgSel  in  SEL_W  channel to configure.
- CfgDiv  in  DIV_W  new divide value for CfgSel; ratio = CfgDiv+1.
- Count  out  NCH*WIDTH  flat bus of registered counts; channel i occupies [i*WIDTH +: WIDTH].
- Ovf  out  NCH  per-channel overflow indication.

Behaviour:
- Reset=1 at an edge, for all channels: Count=0, prescaler=0, Div=0, Ovf=0. Reset overrides every other input, including mid-count.
- Per-channel state: count[WIDTH], pre[DIV_W], div[DIV_W], ovf.
- An event hits channel i when En=1 and Sel==i. Sel values >= NCH are ignored (no state change).
- On an event:
  - If pre==div: pre<=0 and count<=count+1.
  - Otherwise: pre<=pre+1 and count is held.
- With div=0, every event increments the count.
- Priority per channel, highest first:
  1. Reset.
  2. Clr hit: count, pre and ovf go to 0; div is kept.
  3. CfgWe hit: div<=CfgDiv, pre<=0; a same-cycle event is dropped and count is held.
  4. Event.
- Clr, CfgWe and an event may target different channels in the same cycle; each channel applies its own actions independently.
- Latency: registered outputs. An event sampled at edge k is visible on Count after edge k.
- Arithmetic is modulo 2^WIDTH. Count never depends on combinational inputs.
- Wrap (default build):
  - An increment from all-ones wraps count to 0.
  - Ovf[i] pulses high for exactly one cycle, the cycle in which count reads 0 after the wrap.
- No state machine beyond the per-channel prescaler. The pre counter is a mod-(div+1) sequencer.

Optional Feature:
- Macro: PRESCALED_COUNTER_SATURATE_EN.
- Defined:
  - An increment at all-ones holds count at all-ones.
  - Ovf[i] becomes sticky: set on the first blocked increment, cleared only by Reset or Clr of that channel.
  - The prescaler keeps cycling normally.
- Undefined: wrap behaviour as above, with the Ovf one-cycle pulse.

Decomposition:
- Package prescaled_counter_pkg holds:
  - the sel_width(n) function, returning max(1, clog2(n));
  - localparam priority encoding, used only for documentation and assertions.
- One sub-module, prescaled_counter_ch: a single channel with inputs hit, clr, cfg_we, cfg_div; outputs count and ovf.
- The top level decodes Sel, ClrSel and CfgSel into one-hot hit vectors and instantiates NCH channels in a generate loop.

Test Plan:
- Baseline: NCH=2, ch0 Div=0, ch1 CfgDiv=3 written once, then 5 events to ch0 and 8 to ch1 -> Count ch0=5, ch1=2. With En=0 for 10 cycles, both counts are unchanged.
- Wrap: WIDTH=4, Div=0, 16 events to ch0 -> Count ch0 is 15 after event 15, then 0 after event 16. Ovf[0]=1 for exactly one cycle, then 0.
- Saturate (macro defined): WIDTH=4, 18 events -> Count stays 15. Ovf[0] rises after event 16 and stays 1. Clr ch0 -> Count 0, Ovf 0.
- Collisions:
  - Clr and event on ch1 in the same cycle with Count=7 -> Count 0.
  - CfgWe and event on ch0 in the same cycle -> event dropped, pre=0.
  - Event on ch0 plus Clr on ch1 in the same cycle -> both take effect.
- Prescaler reprogram: ch1 Div=3 with 2 events pending (pre=2), write CfgDiv=1 -> the next 2 events give +1. An out-of-range Sel, with NCH=3 and Sel=3, changes nothing.
- Reset mid-operation: counts nonzero, Ovf sticky, Div=3, then Reset for 1 cycle -> all Count=0, Ovf=0, Div=0. The next event increments immediately.

Source files
------------

// File: rtl/prescaled_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_counter_pkg
// Purpose  : Shared helpers and precedence encoding for prescaled_counter_bank.
// Revision : 1.0 - initial release
// ============================================================================
package prescaled_counter_pkg;

    // Per-channel action precedence; a lower value wins.
    localparam int unsigned c_PRIO_RESET = 0;
    localparam int unsigned c_PRIO_CLR   = 1;
    localparam int unsigned c_PRIO_CFG   = 2;
    localparam int unsigned c_PRIO_EVENT = 3;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prescaled_counter_ch.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_counter_ch
// Purpose  : One prescaled event counter with clear, divider config and
//            wrap / overflow flag. PRESCALED_COUNTER_SATURATE_EN selects
//            saturation with a sticky overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module prescaled_counter_ch
    import prescaled_counter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIV_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [WIDTH-1:0] r_count_q, w_count_d;
    logic [DIV_W-1:0] r_pre_q,   w_pre_d;
    logic [DIV_W-1:0] r_div_q,   w_div_d;
    logic             r_ovf_q,   w_ovf_d;

    always_comb begin
        w_count_d = r_count_q;
        w_pre_d   = r_pre_q;
        w_div_d   = r_div_q;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        w_ovf_d   = r_ovf_q;
`else
        w_ovf_d   = 1'b0;
`endif
        if (clr) begin
            w_count_d = '0;
            w_pre_d   = '0;
            w_ovf_d   = 1'b0;
        end else if (cfg_w_we_active()) begin
            w_div_d   = cfg_div;
            w_pre_d   = '0;
        end else if (hit) begin
            if (r_pre_q == r_div_q) begin
                w_pre_d = '0;
                if (&r_count_q) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                    w_ovf_d   = 1'b1;
`else
                    w_count_d = '0;
                    w_ovf_d   = 1'b1;
`endif
                end else begin
                    w_count_d = r_count_q + WIDTH'(1);
                end
            end else begin
                w_pre_d = r_pre_q + DIV_W'(1);
            end
        end
    end

    function automatic logic cfg_w_we_active();
        return cfg_we;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
            r_pre_q   <= '0;
            r_div_q   <= '0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_pre_q   <= w_pre_d;
            r_div_q   <= w_div_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign count = r_count_q;
    assign ovf   = r_ovf_q;

    // Tie the precedence ranking to what the next-state logic actually does.
    a_clr_over_cfg: assert property (@(posedge clk) disable iff (rst)
        (clr && (c_PRIO_RESET < c_PRIO_CLR) && (c_PRIO_CLR < c_PRIO_CFG))
        |=> (r_count_q == '0 && r_pre_q == '0 && !r_ovf_q));

    a_cfg_over_event: assert property (@(posedge clk) disable iff (rst)
        (cfg_we && !clr && (c_PRIO_CFG < c_PRIO_EVENT))
        |=> (r_pre_q == '0 && r_count_q == $past(r_count_q)));

endmodule
`default_nettype wire

// File: rtl/prescaled_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_counter_bank
// Purpose  : Bank of NCH prescaled event counters with select decode.
//            Build option PRESCALED_COUNTER_SATURATE_EN: saturate + sticky Ovf.
// Revision : 1.0 - initial release
// ============================================================================
module prescaled_counter_bank
    import prescaled_counter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NCH   = 2,
    parameter int DIV_W = 2,
    parameter int SEL_W = sel_width(NCH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En,
    input  logic [SEL_W-1:0]     Sel,
    input  logic                 Clr,
    input  logic [SEL_W-1:0]     ClrSel,
    input  logic                 CfgWe,
    input  logic [SEL_W-1:0]     CfgSel,
    input  logic [DIV_W-1:0]     CfgDiv,
    output logic [NCH*WIDTH-1:0] Count,
    output logic [NCH-1:0]       Ovf
);

    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_clr;
    logic [NCH-1:0] w_cfg;

    // Selects at or above NCH match no channel and are therefore ignored.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_hit[i] = En    && (Sel    == SEL_W'(i));
        assign w_clr[i] = Clr   && (ClrSel == SEL_W'(i));
        assign w_cfg[i] = CfgWe && (CfgSel == SEL_W'(i));

        prescaled_counter_ch #(
            .WIDTH (WIDTH),
            .DIV_W (DIV_W)
        ) u_ch (
            .clk     (Clk),
            .rst     (Reset),
            .hit     (w_hit[i]),
            .clr     (w_clr[i]),
            .cfg_we  (w_cfg[i]),
            .cfg_div (CfgDiv),
            .count   (Count[i*WIDTH +: WIDTH]),
            .ovf     (Ovf[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_prescaled_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_prescaled_counter_bank
// Purpose  : Directed vector bench for prescaled_counter_bank (4-bit, 3 ch).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prescaled_counter_bank;

    localparam int WIDTH = 4;
    localparam int NCH   = 3;
    localparam int DIV_W = 2;
    localparam int SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst, en, clr, cfg_we;
    logic [SEL_W-1:0]     sel, clr_sel, cfg_sel;
    logic [DIV_W-1:0]     cfg_div;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH-1:0]       ovf;

    always #5 clk = ~clk;

    prescaled_counter_bank #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .DIV_W (DIV_W)
    ) dut (
        .Clk    (clk),
        .Reset  (rst),
        .En     (en),
        .Sel    (sel),
        .Clr    (clr),
        .ClrSel (clr_sel),
        .CfgWe  (cfg_we),
        .CfgSel (cfg_sel),
        .CfgDiv (cfg_div),
        .Count  (count),
        .Ovf    (ovf)
    );

    typedef struct {
        string             name;
        logic              rst, en, clr, we;
        logic [SEL_W-1:0]  sel, clr_sel, cfg_sel;
        logic [DIV_W-1:0]  div;
        logic [WIDTH-1:0]  e0, e1, e2;
        logic [NCH-1:0]    eovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input string name, input int r, input int e, input int s,
                                input int c, input int cs, input int w, input int ws, input int d,
                                input int e0, input int e1, input int e2, input int eo);
        vec_t v;
        v.name = name; v.rst = r[0]; v.en = e[0]; v.sel = s[SEL_W-1:0];
        v.clr = c[0]; v.clr_sel = cs[SEL_W-1:0]; v.we = w[0]; v.cfg_sel = ws[SEL_W-1:0];
        v.div = d[DIV_W-1:0]; v.e0 = e0[WIDTH-1:0]; v.e1 = e1[WIDTH-1:0];
        v.e2 = e2[WIDTH-1:0]; v.eovf = eo[NCH-1:0];
        return v;
    endfunction

    function automatic vec_t ev(input string name, input int s,
                                input int e0, input int e1, input int e2, input int eo);
        return mk(name, 0, 1, s, 0, 0, 0, 0, 0, e0, e1, e2, eo);
    endfunction

    // Expected ch0 count / ovf after the k-th event of a run from 0 with div=0.
    function automatic int run_cnt(input int k);
`ifdef PRESCALED_COUNTER_SATURATE_EN
        return (k >= 15) ? 15 : k;
`else
        return k % 16;
`endif
    endfunction

    function automatic int run_ovf(input int k);
`ifdef PRESCALED_COUNTER_SATURATE_EN
        return (k >= 16) ? 1 : 0;
`else
        return (k == 16) ? 1 : 0;
`endif
    endfunction

    task automatic step(input vec_t v);
        logic [NCH*WIDTH-1:0] exp_cnt;
        @(negedge clk);
        rst = v.rst; en = v.en; sel = v.sel; clr = v.clr; clr_sel = v.clr_sel;
        cfg_we = v.we; cfg_sel = v.cfg_sel; cfg_div = v.div;
        @(posedge clk);
        #1;
        exp_cnt = {v.e2, v.e1, v.e0};
        n_vec++;
        if (count !== exp_cnt || ovf !== v.eovf) begin
            n_err++;
            $display("FAIL %s (vec %0d): Count=%h Ovf=%b, expected Count=%h Ovf=%b",
                     v.name, n_vec, count, ovf, exp_cnt, v.eovf);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; sel = '0; clr = 1'b0; clr_sel = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;

        vecs.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("cfg_ch1_div3", 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) vecs.push_back(ev("base_ch0", 0, k, 0, 0, 0));
        for (int j = 1; j <= 8; j++) vecs.push_back(ev("base_ch1_div4", 1, 5, j / 4, 0, 0));
        for (int j = 0; j < 10; j++) vecs.push_back(mk("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0, 5, 2, 0, 0));
        vecs.push_back(mk("cfg_ch1_div0", 0, 0, 0, 0, 0, 1, 1, 0, 5, 2, 0, 0));
        for (int j = 1; j <= 5; j++) vecs.push_back(ev("ch1_to_7", 1, 5, 2 + j, 0, 0));
        vecs.push_back(mk("clr_plus_event_ch1", 0, 1, 1, 1, 1, 0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk("cfg_plus_event_ch0", 0, 1, 0, 0, 0, 1, 0, 1, 5, 0, 0, 0));
        vecs.push_back(ev("ch0_div2_first", 0, 5, 0, 0, 0));
        vecs.push_back(ev("ch0_div2_second", 0, 6, 0, 0, 0));
        vecs.push_back(ev("ch1_event", 1, 6, 1, 0, 0));
        vecs.push_back(ev("ch0_pre_step", 0, 6, 1, 0, 0));
        vecs.push_back(mk("ev_ch0_clr_ch1", 0, 1, 0, 1, 1, 0, 0, 0, 7, 0, 0, 0));
        vecs.push_back(mk("cfg_ch1_div3_b", 0, 0, 0, 0, 0, 1, 1, 3, 7, 0, 0, 0));
        vecs.push_back(ev("ch1_pre1", 1, 7, 0, 0, 0));
        vecs.push_back(ev("ch1_pre2", 1, 7, 0, 0, 0));
        vecs.push_back(mk("reprog_ch1_div1", 0, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0, 0));
        vecs.push_back(ev("reprog_ev1", 1, 7, 0, 0, 0));
        vecs.push_back(ev("reprog_ev2", 1, 7, 1, 0, 0));
        vecs.push_back(ev("sel_out_of_range", 3, 7, 1, 0, 0));
        vecs.push_back(mk("all_sel_out_of_range", 0, 1, 3, 1, 3, 1, 3, 3, 7, 1, 0, 0));
        vecs.push_back(ev("ch2_event", 2, 7, 1, 1, 0));
        vecs.push_back(mk("clr_ch0_keep_div", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("cfg_ch0_div0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Wrap / saturate run on ch0, then the one-cycle vs sticky overflow.
        for (int k = 1; k <= 18; k++) step(ev("wrap_run", 0, run_cnt(k), 1, 1, run_ovf(k)));
        step(mk("ovf_after_idle", 0, 0, 0, 0, 0, 0, 0, 0, run_cnt(18), 1, 1, run_ovf(19)));
        step(mk("clr_ch0_ovf", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));

        // Reset mid-operation: nonzero counts, div=3 on ch2, overflow raised.
        for (int k = 1; k <= 15; k++) step(ev("refill_ch0", 0, k, 1, 1, 0));
        step(mk("cfg_ch2_div3", 0, 0, 0, 0, 0, 1, 2, 3, 15, 1, 1, 0));
        step(ev("ch2_pre1", 2, 15, 1, 1, 0));
        step(ev("ch2_pre2", 2, 15, 1, 1, 0));
        step(ev("ch0_event16", 0, run_cnt(16), 1, 1, run_ovf(16)));
        step(mk("idle_before_reset", 0, 0, 0, 0, 0, 0, 0, 0, run_cnt(16), 1, 1, run_ovf(17)));
        step(mk("reset_mid_op", 1, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0));
        step(ev("post_reset_ch2", 2, 0, 0, 1, 0));
        step(ev("post_reset_ch1", 1, 0, 1, 1, 0));
        step(ev("post_reset_ch0", 0, 1, 1, 1, 0));

        @(negedge clk);
        en = 1'b0; clr = 1'b0; cfg_we = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
